// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle types and the core <-> data-memory interface.
package data_mem_ctrl_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;            // core acknowledges the response
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;            // request accepted by memory
  } mem_out_s;

endpackage

interface data_mem_ctrl_if;
  import data_mem_ctrl_pkg::*;

  mem_in_s     to_mem_i;
  logic [31:0] data_mem_addr_i;
  mem_out_s    from_mem_o;

  modport master (
    output to_mem_i,
    output data_mem_addr_i,
    input  from_mem_o
  );

  modport slave (
    input  to_mem_i,
    input  data_mem_addr_i,
    output from_mem_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word-organised single-port array behind an
// accept/respond handshake with a programmable wait between the two.
module data_mem_ctrl #(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned latency_p    = 2
) (
  input  logic              clk,
  input  logic              reset,        // synchronous, active-low
  data_mem_ctrl_if.slave    bus,
  output logic              busy_o,
  output logic [15:0]       req_count_o
);
  import data_mem_ctrl_pkg::*;

  localparam int unsigned Depth = 1 << addr_width_p;

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [addr_width_p-1:0] idx_q, idx_d;
  logic [1:0]              lane_q, lane_d;
  logic                    wen_q, wen_d;
  logic                    bnw_q, bnw_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [15:0]             count_q, count_d;
  logic                    accept;
  logic [31:0]             rd_word;
  logic [7:0]              rd_byte;

  logic [31:0]             mem_q [Depth];

  // Upper address bits alias onto the array (wrap-around)
  logic unused_addr;
  assign unused_addr = ^bus.data_mem_addr_i[31:addr_width_p+2];

  assign rd_word = mem_q[idx_q];
  assign rd_byte = rd_word[{lane_q, 3'b000} +: 8];

  // Next-state and datapath decisions for the request FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    wen_d   = wen_q;
    bnw_d   = bnw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    count_d = count_q;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gate with reset so nothing looks accepted on a reset edge
        if (bus.to_mem_i.valid && reset) begin
          accept  = 1'b1;
          idx_d   = bus.data_mem_addr_i[2 +: addr_width_p];
          lane_d  = bus.data_mem_addr_i[1:0];
          wen_d   = bus.to_mem_i.wen;
          bnw_d   = bus.to_mem_i.byte_not_word;
          wdata_d = bus.to_mem_i.write_data;
          cnt_d   = 4'(latency_p);
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          state_d = (latency_p != 0) ? StWait : StAccess;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StAccess;
      end
      StAccess: begin
        if (wen_q)      rdata_d = 32'h0;
        else if (bnw_q) rdata_d = {24'h0, rd_byte};
        else            rdata_d = rd_word;
        state_d = StResp;
      end
      StResp: begin
        if (bus.to_mem_i.yumi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and latched-request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      wen_q   <= 1'b0;
      bnw_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wen_q   <= wen_d;
      bnw_q   <= bnw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end

  // Storage array: written only in ACCESS, contents survive reset
  always_ff @(posedge clk) begin
    if (reset && (state_q == StAccess) && wen_q) begin
      if (bnw_q) mem_q[idx_q][{lane_q, 3'b000} +: 8] <= wdata_q[7:0];
      else       mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.from_mem_o = '{read_data: rdata_q,
                            valid:     (state_q == StResp),
                            yumi:      accept};
  assign busy_o      = (state_q != StIdle);
  assign req_count_o = count_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl (latency 2 and latency 0 builds).
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned Depth = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_ctrl_if bus_a ();
  data_mem_ctrl_if bus_b ();

  logic        busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;

  data_mem_ctrl #(.addr_width_p(AW), .latency_p(2)) u_dut_a (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus_a),
    .busy_o      (busy_a),
    .req_count_o (cnt_a)
  );

  data_mem_ctrl #(.addr_width_p(AW), .latency_p(0)) u_dut_b (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus_b),
    .busy_o      (busy_b),
    .req_count_o (cnt_b)
  );

  // sel picks which DUT the tasks drive and observe
  logic        sel;
  mem_in_s     req;
  logic [31:0] req_addr;
  mem_out_s    rsp;
  logic        busy;
  logic [15:0] count;

  assign bus_a.to_mem_i        = sel ? '0 : req;
  assign bus_b.to_mem_i        = sel ? req : '0;
  assign bus_a.data_mem_addr_i = req_addr;
  assign bus_b.data_mem_addr_i = req_addr;
  assign rsp   = sel ? bus_b.from_mem_o : bus_a.from_mem_o;
  assign busy  = sel ? busy_b : busy_a;
  assign count = sel ? cnt_b : cnt_a;

  int          checks;
  int          errors;
  int          overlap;
  logic [31:0] model_mem [2][Depth];
  int unsigned model_cnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: array of words, byte lanes by arithmetic
  function automatic logic [31:0] model_op(input logic [31:0] a, input logic w, input logic b,
                                           input logic [31:0] d);
    int unsigned idx, sh;
    logic [31:0] word;
    idx  = (a / 4) % Depth;
    sh   = (a % 4) * 8;
    word = model_mem[sel][idx];
    if (w) begin
      if (b) model_mem[sel][idx] = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      else   model_mem[sel][idx] = d;
      return 32'h0;
    end
    if (b) return (word >> sh) & 32'hFF;
    return word;
  endfunction

  function automatic int exp_lat();
    return (sel ? 0 : 2) + 2;
  endfunction

  // Present a request until accepted; ends one cycle after acceptance
  task automatic issue(input logic [31:0] a, input logic w, input logic b, input logic [31:0] d);
    int n = 0;
    req_addr          = a;
    req.write_data    = d;
    req.wen           = w;
    req.byte_not_word = b;
    req.valid         = 1'b1;
    #1;
    while (rsp.yumi !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept", {31'd0, rsp.yumi}, 32'd1);
    if (rsp.yumi === 1'b1) model_cnt[sel]++;
    @(negedge clk);
    req.valid = 1'b0;
    #1;
    check("req_count", {16'd0, count}, model_cnt[sel]);
  endtask

  // Count cycles until valid; optionally throw ignored requests at the DUT meanwhile
  task automatic await_resp(input logic poke, output int lat);
    lat = 1;
    while (rsp.valid !== 1'b1 && lat < 40) begin
      if (poke) begin
        req_addr  = $urandom();
        req.valid = 1'b1;
        #1;
        check("busy_no_accept", {31'd0, rsp.yumi}, 32'd0);
        check("busy_flag", {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      #1;
      lat++;
    end
    req.valid = 1'b0;
    #1;
  endtask

  task automatic ack(input int stall, input logic [31:0] exp, output logic [31:0] rd);
    for (int i = 0; i <= stall; i++) begin
      check("resp_valid", {31'd0, rsp.valid}, 32'd1);
      check("read_data", rsp.read_data, exp);
      if (i < stall) begin
        @(negedge clk);
        #1;
      end
    end
    rd       = rsp.read_data;
    req.yumi = 1'b1;
    @(negedge clk);
    req.yumi = 1'b0;
    #1;
    check("valid_drop", {31'd0, rsp.valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic txn(input logic [31:0] a, input logic w, input logic b, input logic [31:0] d,
                     input int stall, input logic poke, output logic [31:0] rd);
    logic [31:0] exp;
    int          lat;
    exp = model_op(a, w, b, d);
    issue(a, w, b, d);
    await_resp(poke, lat);
    check("latency", lat, exp_lat());
    ack(stall, exp, rd);
  endtask

  // Response valid and accept must never coincide on either DUT
  initial begin
    overlap = 0;
    forever begin
      @(negedge clk);
      #4;
      if ((bus_a.from_mem_o.valid && bus_a.from_mem_o.yumi) ||
          (bus_b.from_mem_o.valid && bus_b.from_mem_o.yumi)) overlap++;
    end
  end

  initial begin
    logic [31:0] rd, r, a;
    int          lat;
    checks       = 0;
    errors       = 0;
    req          = '0;
    req_addr     = '0;
    sel          = 1'b0;
    rst_n        = 1'b0;
    model_cnt[0] = 0;
    model_cnt[1] = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, rsp.valid}, 32'd0);
    check("rst_yumi", {31'd0, rsp.yumi}, 32'd0);
    check("rst_rdata", rsp.read_data, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Give every word the random phase touches a known value
    for (int i = 0; i < 16; i++) txn(i * 4, 1'b1, 1'b0, $urandom(), 0, 1'b0, rd);

    // Random traffic: word indices 0..15, random upper (ignored) bits and lanes
    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      a = (r & 32'hFFFF_F000) | (r & 32'h0000_003F);
      txn(a, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom(),
          $urandom_range(3, 0), 1'($urandom_range(1, 0)), rd);
    end

    // Word store/load
    txn(32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 0, 1'b0, rd);
    check("tp_word_write_rd", rd, 32'h0);
    txn(32'h10, 1'b0, 1'b0, 32'h0, 0, 1'b0, rd);
    check("tp_word_load", rd, 32'hDEADBEEF);

    // Byte lanes
    txn(32'h20, 1'b1, 1'b0, 32'h11223344, 0, 1'b0, rd);
    txn(32'h22, 1'b1, 1'b1, 32'h000000AA, 0, 1'b0, rd);
    txn(32'h20, 1'b0, 1'b0, 32'h0, 0, 1'b0, rd);
    check("tp_byte_merge", rd, 32'h11AA3344);
    txn(32'h23, 1'b0, 1'b1, 32'h0, 1, 1'b0, rd);
    check("tp_byte_load", rd, 32'h00000011);

    // Stalled ack, then a request presented in the ack cycle
    rd = model_op(32'h10, 1'b0, 1'b0, 32'h0);
    issue(32'h10, 1'b0, 1'b0, 32'h0);
    await_resp(1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, rsp.valid}, 32'd1);
      check("stall_rdata", rsp.read_data, 32'hDEADBEEF);
      @(negedge clk);
      #1;
    end
    req.yumi  = 1'b1;
    req_addr  = 32'h10;
    req.wen   = 1'b0;
    req.byte_not_word = 1'b0;
    req.valid = 1'b1;
    #1;
    check("ack_cycle_no_accept", {31'd0, rsp.yumi}, 32'd0);
    @(negedge clk);
    req.yumi = 1'b0;
    #1;
    check("valid_after_ack", {31'd0, rsp.valid}, 32'd0);
    check("accept_next_cycle", {31'd0, rsp.yumi}, 32'd1);
    rd = model_op(32'h10, 1'b0, 1'b0, 32'h0);
    issue(32'h10, 1'b0, 1'b0, 32'h0);
    await_resp(1'b0, lat);
    check("b2b_latency", lat, exp_lat());
    ack(0, 32'hDEADBEEF, rd);

    // Wrap-around and ignored requests during WAIT
    txn(32'h1000_0004, 1'b1, 1'b0, 32'h5, 0, 1'b1, rd);
    txn(32'h4, 1'b0, 1'b0, 32'h0, 0, 1'b1, rd);
    check("tp_wrap", rd, 32'h5);

    // Reset during WAIT abandons a pending write
    txn(32'h30, 1'b1, 1'b0, 32'h1, 0, 1'b0, rd);
    issue(32'h30, 1'b1, 1'b0, 32'hFFFFFFFF);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, rsp.valid}, 32'd0);
    check("mid_rst_rdata", rsp.read_data, 32'd0);
    check("mid_rst_count", {16'd0, count}, 32'd0);
    rst_n        = 1'b1;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    @(negedge clk);
    #1;
    txn(32'h30, 1'b0, 1'b0, 32'h0, 0, 1'b0, rd);
    check("tp_abandoned_write", rd, 32'h1);

    // Zero-latency build
    sel = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      txn(i * 4, 1'b1, 1'b0, $urandom(), 0, 1'b1, rd);
      check("lat0_write_rd", rd, 32'h0);
    end
    txn(32'h8, 1'b1, 1'b0, 32'hCAFE1234, 0, 1'b0, rd);
    txn(32'h9, 1'b1, 1'b1, 32'h0000005A, 2, 1'b0, rd);
    txn(32'h8, 1'b0, 1'b0, 32'h0, 0, 1'b0, rd);
    check("lat0_word", rd, 32'hCAFE5A34);
    txn(32'hB, 1'b0, 1'b1, 32'h0, 0, 1'b0, rd);
    check("lat0_byte", rd, 32'h000000CA);

    check("valid_yumi_overlap", overlap, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
